sprite_linewriter: RTL and testbench

- Read-modify-write sprite rasteriser that feeds the write port of the video line buffer.
- Accepts one sprite row at a time: X position, 4 bitplanes and an 8-pixel row. Merges opaque pixels into the line currently being built, honouring tile priority and first-sprite-wins.
- Flags sprite-sprite collisions.
- Sits between the sprite fetch/evaluation stage (upstream) and the line buffer port 1 (downstream).

---
 rtl/vdp_lb_pkg.sv | 24 ++
 rtl/sprite_pix_merge.sv | 42 ++++
 rtl/sprite_linewriter.sv | 117 +++++++++++
 tb/tb_sprite_linewriter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_lb_pkg.sv
// Shared line-buffer byte layout and sprite-writer FSM states.
// Byte format: [4:0] colour, [5] tile priority, [6] sprite drawn, [7] reserved.
package vdp_lb_pkg;

   localparam int LB_W        = 8;
   localparam int LB_COL_MSB  = 4;
   localparam int LB_PRIO_BIT = 5;
   localparam int LB_SPR_BIT  = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } lw_state_e;

   // Bit 7 of each plane is the leftmost pixel; bit 4 of the result marks sprite palette.
   function automatic logic [LB_COL_MSB:0] pix_colour(input logic [3:0][7:0] planes,
                                                      input logic [2:0]      pix);
      logic [2:0] idx;
      idx = 3'd7 - pix;
      return {1'b1, planes[3][idx], planes[2][idx], planes[1][idx], planes[0][idx]};
   endfunction

endpackage

// File: rtl/sprite_pix_merge.sv
// Combinational merge of one sprite pixel against the byte read from the line buffer.
// Decides whether to write, what to write, and whether two sprites collided.
module sprite_pix_merge
   import vdp_lb_pkg::*;
(
   input  logic [9:0]          pix_x_i,
   input  logic [LB_COL_MSB:0] colour_i,
   input  logic [LB_W-1:0]     rd_i,
   output logic                wren_o,
   output logic [LB_W-1:0]     wrdata_o,
   output logic                coll_o
);

   localparam logic [9:0] LINE_END = 10'd256;

   logic on_line;
   logic opaque;
   logic rd_unused;

   assign on_line   = (pix_x_i < LINE_END);
   assign opaque    = (colour_i[3:0] != 4'd0);
   assign rd_unused = rd_i[7];

   always_comb begin
      wren_o   = 1'b0;
      wrdata_o = '0;
      coll_o   = 1'b0;
      if (on_line && opaque) begin
         if (rd_i[LB_SPR_BIT]) begin
            coll_o = 1'b1;
         end else if (rd_i[LB_PRIO_BIT] && (rd_i[3:0] != 4'd0)) begin
            // Sprite hidden behind an opaque priority tile, but it still claims the pixel.
            wren_o   = 1'b1;
            wrdata_o = {1'b0, 1'b1, rd_i[5:0]};
         end else begin
            wren_o   = 1'b1;
            wrdata_o = {2'b01, rd_i[LB_PRIO_BIT], colour_i};
         end
      end
   end

endmodule

// File: rtl/sprite_linewriter.sv
// Read-modify-write sprite rasteriser: one 8-pixel sprite row per entry, two cycles per pixel
// (read then write) into line-buffer port 1, with a sticky sprite collision flag.
module sprite_linewriter
   import vdp_lb_pkg::*;
#(
   parameter int PIX_PER_SPR = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            spr_valid,
   output logic            spr_ready,
   input  logic [8:0]      spr_x,
   input  logic [7:0]      spr_p0,
   input  logic [7:0]      spr_p1,
   input  logic [7:0]      spr_p2,
   input  logic [7:0]      spr_p3,
   output logic            busy,
   output logic            coll,
   input  logic            coll_clr,
   output logic [LB_W-1:0] lb_idx,
   input  logic [LB_W-1:0] lb_rddata,
   output logic [LB_W-1:0] lb_wrdata,
   output logic            lb_wren
);

   localparam logic [2:0] LAST_PIX = 3'(PIX_PER_SPR - 1);

   lw_state_e        state_q, state_d;
   logic             armed_q;
   logic [8:0]       x_q, x_d;
   logic [2:0]       pix_q, pix_d;
   logic             coll_q, coll_d;
   logic [3:0][7:0]  planes_q;
   logic             ld_planes;

   logic [9:0]          pix_x;
   logic [LB_COL_MSB:0] colour;
   logic                m_wren;
   logic [LB_W-1:0]     m_wrdata;
   logic                m_coll;
   logic                in_wr;

   // Pixel X kept at 10 bits so sprites near X=511 never wrap onto the left edge.
   assign pix_x  = {1'b0, x_q} + {7'd0, pix_q};
   assign colour = pix_colour(planes_q, pix_q);
   assign in_wr  = (state_q == WR);

   sprite_pix_merge u_merge (
      .pix_x_i  (pix_x),
      .colour_i (colour),
      .rd_i     (lb_rddata),
      .wren_o   (m_wren),
      .wrdata_o (m_wrdata),
      .coll_o   (m_coll)
   );

   // armed_q keeps spr_ready low in the cycle reset deasserts.
   assign spr_ready = (state_q == IDLE) && armed_q;
   assign busy      = (state_q != IDLE);
   assign coll      = coll_q;
   assign lb_idx    = pix_x[7:0];
   assign lb_wren   = in_wr && m_wren;
   assign lb_wrdata = lb_wren ? m_wrdata : '0;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      pix_d     = pix_q;
      ld_planes = 1'b0;
      case (state_q)
         IDLE: begin
            if (spr_valid && spr_ready) begin
               x_d       = spr_x;
               pix_d     = 3'd0;
               ld_planes = 1'b1;
               state_d   = RD;
            end
         end
         RD: state_d = WR;
         WR: begin
            if (pix_q == LAST_PIX) begin
               state_d = IDLE;
            end else begin
               pix_d   = pix_q + 3'd1;
               state_d = RD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A collision in the same cycle as coll_clr leaves the flag set.
   assign coll_d = (in_wr && m_coll) || (coll_q && !coll_clr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         x_q     <= '0;
         pix_q   <= '0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         x_q     <= x_d;
         pix_q   <= pix_d;
         coll_q  <= coll_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_planes) begin
         planes_q <= {spr_p3, spr_p2, spr_p1, spr_p0};
      end
   end

endmodule

// File: tb/tb_sprite_linewriter.sv
// Bench for sprite_linewriter: behavioural line-buffer model checked every cycle,
// plus directed entries with hand-computed buffer contents.
module tb_sprite_linewriter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       spr_valid = 1'b0;
   logic       spr_ready;
   logic [8:0] spr_x = '0;
   logic [7:0] spr_p0 = '0, spr_p1 = '0, spr_p2 = '0, spr_p3 = '0;
   logic       busy, coll;
   logic       coll_clr = 1'b0;
   logic [7:0] lb_idx, lb_rddata, lb_wrdata;
   logic       lb_wren;

   logic       pl_clr = 1'b0, pl_en = 1'b0;
   logic [7:0] pl_addr = '0, pl_data = '0;

   logic [7:0] mem [256];
   logic [7:0] ref_lb [256];
   int         n_chk = 0, n_fail = 0;
   int         cyc = 0, n_wr = 0;

   always #5 clk = ~clk;

   sprite_linewriter #(.PIX_PER_SPR(8)) dut (
      .clk(clk), .reset(reset), .spr_valid(spr_valid), .spr_ready(spr_ready),
      .spr_x(spr_x), .spr_p0(spr_p0), .spr_p1(spr_p1), .spr_p2(spr_p2), .spr_p3(spr_p3),
      .busy(busy), .coll(coll), .coll_clr(coll_clr), .lb_idx(lb_idx),
      .lb_rddata(lb_rddata), .lb_wrdata(lb_wrdata), .lb_wren(lb_wren)
   );

   // Line buffer port 1 with one-cycle read latency.
   always @(posedge clk) begin
      if (pl_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (lb_wren) begin
         mem[lb_idx] <= lb_wrdata;
      end
      lb_rddata <= mem[lb_idx];
      cyc       <= cyc + 1;
      if (lb_wren) n_wr <= n_wr + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pixel rule: returns {wren, collision, wrdata}.
   function automatic logic [9:0] decide(input int px, input logic [3:0][7:0] pl,
                                         input int pix, input logic [7:0] rd);
      int b, c;
      b = 7 - pix;
      c = 0;
      if (pl[3][b]) c += 8;
      if (pl[2][b]) c += 4;
      if (pl[1][b]) c += 2;
      if (pl[0][b]) c += 1;
      if (px >= 256 || c == 0) return 10'h000;
      if (rd[6]) return 10'h100;
      if (rd[5] && rd[3:0] != 4'd0) return {2'b10, 8'h40 | (rd & 8'h3F)};
      return {2'b10, 8'h50 | (rd & 8'h20) | 8'(c)};
   endfunction

   // Model: mphase 0 = idle, 1..16 = the 16 cycles of an entry (odd=read, even=write).
   int              mphase = 0, mx = 0;
   logic [3:0][7:0] mpl = '0;
   bit              armed = 1'b0;
   logic            ref_coll = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mphase   = 0;
         armed    = 1'b0;
         ref_coll = 1'b0;
      end else begin : model_step
         logic [9:0] r;
         int pix, px;
         r = '0;
         if (pl_clr) begin
            for (int i = 0; i < 256; i++) ref_lb[i] = 8'h00;
         end else if (pl_en) begin
            ref_lb[pl_addr] = pl_data;
         end
         if (mphase != 0 && mphase % 2 == 0) begin
            pix = mphase / 2 - 1;
            px  = mx + pix;
            r   = decide(px, mpl, pix, ref_lb[px & 255]);
            if (r[9]) ref_lb[px & 255] = r[7:0];
         end
         ref_coll = r[8] | (ref_coll & !coll_clr);
         if (mphase == 0) begin
            if (armed && spr_valid) begin
               mx     = int'(spr_x);
               mpl    = {spr_p3, spr_p2, spr_p1, spr_p0};
               mphase = 1;
            end
         end else if (mphase == 16) begin
            mphase = 0;
         end else begin
            mphase++;
         end
         armed = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin : cmp
         logic [9:0] r;
         int pix;
         chk("ready", spr_ready, (mphase == 0) && armed);
         chk("busy", busy, mphase != 0);
         chk("coll", coll, ref_coll);
         if (mphase == 0) begin
            chk("wren_idle", lb_wren, 0);
         end else begin
            pix = (mphase - 1) / 2;
            chk("idx", lb_idx, (mx + pix) & 255);
            if (mphase % 2 == 0) begin
               r = decide(mx + pix, mpl, pix, ref_lb[(mx + pix) & 255]);
               chk("wren_wr", lb_wren, r[9]);
               if (r[9]) chk("wrdata", lb_wrdata, r[7:0]);
            end else begin
               chk("wren_rd", lb_wren, 0);
            end
         end
      end
   end

   int t_acc, wr0;

   task automatic clear_lb();
      @(negedge clk) pl_clr = 1'b1;
      @(negedge clk) pl_clr = 1'b0;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = v;
      @(negedge clk) pl_en = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk) coll_clr = 1'b1;
      @(negedge clk) coll_clr = 1'b0;
   endtask

   task automatic send(input logic [8:0] x, input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3);
      int n;
      n = 0;
      @(negedge clk);
      while (!spr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 1, 0);
      spr_valid = 1'b1; spr_x = x;
      spr_p0 = p0; spr_p1 = p1; spr_p2 = p2; spr_p3 = p3;
      wr0 = n_wr;
      @(negedge clk);
      spr_valid = 1'b0;
      t_acc = cyc;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 40);
      if (n >= 40) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", spr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_coll", coll, 0);
      chk("rst_idx", lb_idx, 0);
      chk("rst_wrdata", lb_wrdata, 0);
      chk("rst_wren", lb_wren, 0);
      reset = 1'b0;
      #1 chk("ready_at_release", spr_ready, 0);
      clear_lb();

      // Single entry
      send(9'd10, 8'hFF, 8'h00, 8'h00, 8'h00);
      wait_idle();
      chk("t1_dur", cyc - t_acc, 16);
      chk("t1_nwr", n_wr - wr0, 8);
      for (int i = 10; i < 18; i++) chk("t1_byte", mem[i], 8'h51);
      chk("t1_left", mem[9], 8'h00);
      chk("t1_right", mem[18], 8'h00);
      chk("t1_coll", coll, 0);

      // Overlapping entries
      clear_lb();
      send(9'd20, 8'hFF, 8'h00, 8'h00, 8'h00);
      wait_idle();
      send(9'd24, 8'h00, 8'hFF, 8'h00, 8'h00);
      wait_idle();
      for (int i = 20; i < 28; i++) chk("t2_first", mem[i], 8'h51);
      for (int i = 28; i < 32; i++) chk("t2_second", mem[i], 8'h52);
      chk("t2_coll", coll, 1);

      // Transparent pixels
      pulse_clr();
      chk("t3_clr", coll, 0);
      clear_lb();
      send(9'd30, 8'hAA, 8'h00, 8'h00, 8'h00);
      wait_idle();
      chk("t3_nwr", n_wr - wr0, 4);
      for (int i = 30; i < 38; i += 2) chk("t3_opaque", mem[i], 8'h51);
      for (int i = 31; i < 38; i += 2) chk("t3_transp", mem[i], 8'h00);

      // Priority tile
      clear_lb();
      preload(8'd40, 8'h23);
      send(9'd40, 8'h80, 8'h00, 8'h00, 8'h00);
      wait_idle();
      chk("t4_hidden", mem[40], 8'h63);
      chk("t4_coll0", coll, 0);
      send(9'd40, 8'h00, 8'h80, 8'h00, 8'h00);
      wait_idle();
      chk("t4_kept", mem[40], 8'h63);
      chk("t4_coll1", coll, 1);

      // Right edge
      pulse_clr();
      clear_lb();
      send(9'd252, 8'hFF, 8'h00, 8'h00, 8'h00);
      wait_idle();
      chk("t5_dur", cyc - t_acc, 16);
      chk("t5_nwr", n_wr - wr0, 4);
      for (int i = 252; i < 256; i++) chk("t5_byte", mem[i], 8'h51);
      for (int i = 0; i < 4; i++) chk("t5_nowrap", mem[i], 8'h00);

      // Collision and clear in the same cycle
      clear_lb();
      preload(8'd60, 8'h41);
      send(9'd60, 8'h80, 8'h00, 8'h00, 8'h00);
      pulse_clr();
      wait_idle();
      chk("t6_setwins", coll, 1);
      chk("t6_byte", mem[60], 8'h41);

      // Async reset during pixel 3
      clear_lb();
      send(9'd0, 8'hFF, 8'h00, 8'h00, 8'h00);
      begin
         int n;
         n = 0;
         while (mphase != 8 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) chk("t7_phase_timeout", 1, 0);
      end
      reset = 1'b1;
      #1;
      chk("t7_wren", lb_wren, 0);
      chk("t7_busy", busy, 0);
      chk("t7_ready", spr_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk("t7_ready_rel", spr_ready, 0);
      @(negedge clk);
      chk("t7_ready_after", spr_ready, 1);
      chk("t7_coll", coll, 0);
      for (int i = 0; i < 3; i++) chk("t7_written", mem[i], 8'h51);
      for (int i = 3; i < 8; i++) chk("t7_untouched", mem[i], 8'h00);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
